// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MaxNet winner-take-all controller.
// Used by maxnet_controller, maxnet_result_pipe and the PU bus interface.
package maxnet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic signed [4:0] W_ONE = 5'sd8;
    localparam int FRAC    = 3;
    localparam int ACT_MAX = 15;
    localparam int LANES   = 4;

    // Rescale a Q.3 PU sum back to an activation: floor, then clamp to 0..ACT_MAX.
    function automatic logic [4:0] clamp_result(input logic signed [11:0] v);
        logic [8:0] q;
        q = v[11:FRAC];
        if (v[11]) return 5'd0;
        if (q > 9'(ACT_MAX)) return 5'(ACT_MAX);
        return q[4:0];
    endfunction

endpackage

// File: rtl/maxnet_if.sv
// Operand/result bus between the MaxNet controller (master) and the shared
// 4-lane processing unit (slave); pu_out is valid two cycles after the operands.
interface maxnet_if;
    logic [4:0]  pu_x1, pu_x2, pu_x3, pu_x4;
    logic [4:0]  pu_w1, pu_w2, pu_w3, pu_w4;
    logic [11:0] pu_out;

    modport master (
        output pu_x1, pu_x2, pu_x3, pu_x4,
        output pu_w1, pu_w2, pu_w3, pu_w4,
        input  pu_out
    );

    modport slave (
        input  pu_x1, pu_x2, pu_x3, pu_x4,
        input  pu_w1, pu_w2, pu_w3, pu_w4,
        output pu_out
    );
endinterface

// File: rtl/maxnet_result_pipe.sv
// Two-stage valid/index delay line that tracks results in flight through the
// PU so each returning sum lands in the right shadow slot.
module maxnet_result_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_idx,
    output logic       out_valid,
    output logic [1:0] out_idx
);

    logic       valid_s1, valid_s2;
    logic [1:0] idx_s1, idx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            idx_s1   <= 2'd0;
            idx_s2   <= 2'd0;
        end else begin
            valid_s1 <= in_valid;
            valid_s2 <= valid_s1;
            idx_s1   <= in_idx;
            idx_s2   <= idx_s1;
        end
    end

    assign out_valid = valid_s2;
    assign out_idx   = idx_s2;

endmodule

// File: rtl/maxnet_controller.sv
// Sequences MaxNet iterations through one shared 2-cycle PU, committing all four
// updates together per iteration. Optional iteration cap: MAXNET_ITER_LIMIT_EN.
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        din0,
    input  logic [3:0]        din1,
    input  logic [3:0]        din2,
    input  logic [3:0]        din3,
    input  logic [3:0]        eps,
    maxnet_if.master          pu,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              winner_valid,
    output logic              limit_hit,
    output logic [4:0]        act0,
    output logic [4:0]        act1,
    output logic [4:0]        act2,
    output logic [4:0]        act3,
    output logic [ITER_W-1:0] iter_count,
    output state_t            state_dbg
);

    // Handshake: start is a request taken only on an edge where busy is low;
    // results are stable from the done pulse until the next accepted start.

`ifdef MAXNET_ITER_LIMIT_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    state_t     state, state_n;
    logic [1:0] issue_idx, issue_idx_n;
    logic       drain_cnt, drain_n;
    logic       load, commit, finish;

    logic [4:0] act_q    [LANES];
    logic [4:0] shadow_q [LANES];
    logic [4:0] op_x     [LANES];
    logic [4:0] op_w     [LANES];

    logic [3:0] eps_c;
    logic [4:0] neg_w;
    logic       res_valid;
    logic [1:0] res_idx;
    logic [2:0] nz;
    logic       few_nz;
    logic [1:0] win_idx;
    logic [4:0] best;
    logic       cap_hit;

    assign eps_c = (eps > 4'd8) ? 4'd8 : eps;
    assign neg_w = 5'd0 - {1'b0, eps_c};

    assign cap_hit = CAP_EN &&
                     (({1'b0, iter_count} + (ITER_W+1)'(1)) == (ITER_W+1)'(MAX_ITER));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            issue_idx <= 2'd0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_n;
            issue_idx <= issue_idx_n;
            drain_cnt <= drain_n;
        end
    end

    always_comb begin
        state_n     = state;
        issue_idx_n = issue_idx;
        drain_n     = drain_cnt;
        load        = 1'b0;
        commit      = 1'b0;
        finish      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load        = 1'b1;
                    issue_idx_n = 2'd0;
                    state_n     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue_idx_n = issue_idx + 2'd1;
                if (issue_idx == 2'd3) begin
                    drain_n = 1'b0;
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_n = 1'b1;
                if (drain_cnt) state_n = ST_CHECK;
            end
            ST_CHECK: begin
                commit = 1'b1;
                if (few_nz || cap_hit) begin
                    finish  = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    issue_idx_n = 2'd0;
                    state_n     = ST_ISSUE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Lane i carries the self-excitation weight, all others the inhibition.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            op_x[j] = 5'd0;
            op_w[j] = 5'd0;
            if (state == ST_ISSUE) begin
                op_x[j] = act_q[j];
                op_w[j] = (issue_idx == 2'(j)) ? W_ONE : neg_w;
            end
        end
    end

    assign pu.pu_x1 = op_x[0];
    assign pu.pu_x2 = op_x[1];
    assign pu.pu_x3 = op_x[2];
    assign pu.pu_x4 = op_x[3];
    assign pu.pu_w1 = op_w[0];
    assign pu.pu_w2 = op_w[1];
    assign pu.pu_w3 = op_w[2];
    assign pu.pu_w4 = op_w[3];

    maxnet_result_pipe u_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (state == ST_ISSUE),
        .in_idx   (issue_idx),
        .out_valid(res_valid),
        .out_idx  (res_idx)
    );

    always_comb begin
        nz      = 3'd0;
        best    = shadow_q[0];
        win_idx = 2'd0;
        for (int j = 0; j < LANES; j++) begin
            if (shadow_q[j] != 5'd0) nz = nz + 3'd1;
        end
        for (int j = 1; j < LANES; j++) begin
            if (shadow_q[j] > best) begin
                best    = shadow_q[j];
                win_idx = 2'(j);
            end
        end
    end

    assign few_nz = (nz <= 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < LANES; j++) begin
                act_q[j]    <= 5'd0;
                shadow_q[j] <= 5'd0;
            end
            iter_count   <= '0;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
        end else begin
            if (load) begin
                act_q[0]     <= {1'b0, din0};
                act_q[1]     <= {1'b0, din1};
                act_q[2]     <= {1'b0, din2};
                act_q[3]     <= {1'b0, din3};
                iter_count   <= '0;
                winner       <= 2'd0;
                winner_valid <= 1'b0;
            end
            if (res_valid) shadow_q[res_idx] <= clamp_result($signed(pu.pu_out));
            // Shadow values become visible only here, so every update in an
            // iteration saw the same old activations.
            if (commit) begin
                for (int j = 0; j < LANES; j++) act_q[j] <= shadow_q[j];
                iter_count <= iter_count + ITER_W'(1);
                if (finish) begin
                    winner       <= win_idx;
                    winner_valid <= (nz == 3'd1);
                end
            end
        end
    end

`ifdef MAXNET_ITER_LIMIT_EN
    logic limit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_q <= 1'b0;
        end else if (load) begin
            limit_q <= 1'b0;
        end else if (commit && !few_nz && cap_hit) begin
            limit_q <= 1'b1;
        end
    end

    assign limit_hit = limit_q;
`else
    assign limit_hit = 1'b0;
`endif

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign act0      = act_q[0];
    assign act1      = act_q[1];
    assign act2      = act_q[2];
    assign act3      = act_q[3];
    assign state_dbg = state;

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencing controller that runs the MaxNet winner-take-all competition on one shared processing unit (4-lane multiply, adder tree, 2-cycle registered latency). It loads four activations and issues one neuron update per cycle into the PU. It collects results into shadow registers and commits them synchronously per iteration. It stops when at most one neuron stays non-zero or when the iteration cap is reached.

## Interface
- MAX_ITER, 15: iteration cap, used only when the cap feature is compiled in.
- ITER_W, 4: width of the iteration counter; must hold MAX_ITER.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset. Shared with the PU.
- start  in  1  begin a competition; sampled only in IDLE.
- din0..din3  in  4 each  initial activations, unsigned 0..15.
- eps  in  4  inhibition weight in Q1.3; values above 8 are clamped to 8 (1.0).
- pu_x1..pu_x4  out  5 each  PU activation operands, two's complement.
- pu_w1..pu_w4  out  5 each  PU weight operands, Q1.3 two's complement.
- pu_out  in  12  PU result, valid 2 cycles after the operands.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the competition ends.
- winner  out  2  index of the largest final activation.
- winner_valid  out  1  exactly one final activation is non-zero.
- limit_hit  out  1  the competition ended on the iteration cap.
- act0..act3  out  5 each  committed activations.
- iter_count  out  ITER_W  number of completed iterations.

## Operation
- States: IDLE, ISSUE, DRAIN, CHECK, DONE.
- IDLE, start=1: load act_i={1'b0,din_i}, clear iter_count, clear status, go to ISSUE.
  - start is ignored in every other state.
- ISSUE, 4 cycles, issue index i=0..3:
  - pu_x_j = act_j.
  - pu_w_j = 5'b01000 (+1.0) when j==i, else -eps_clamped.
  - A 2-deep valid/index pipe tracks in-flight results.
  - Outside ISSUE, pu_x and pu_w are driven to 0.
- DRAIN, 2 cycles: wait for the last two results.
- Capture: when the pipe valid is high, shadow[idx] = clamp(pu_out >>> 3, 0, 15).
  - The shift is arithmetic (floor); negative values become 0 (ReLU).
- All four updates in an iteration use the old act values. act changes only in CHECK.
- CHECK, 1 cycle:
  - Commit act=shadow and increment iter_count.
  - nz = number of non-zero shadow entries.
  - nz≤1: go to DONE.
  - Else, cap reached (iter_count+1==MAX_ITER, feature enabled): limit_hit=1, go to DONE.
  - Else: go to ISSUE.
- DONE, 1 cycle: done=1, then IDLE.
  - winner = index of the maximum act; the lowest index wins ties.
  - winner_valid = (nz==1).
  - winner, winner_valid, limit_hit, act and iter_count hold until the next accepted start.
- Reset values: all outputs 0, state IDLE, shadow 0, pipe valid 0.
  - Reset mid-competition abandons it with no done pulse. In-flight PU results are discarded.

## Timing
- One iteration = 7 cycles (4 ISSUE + 2 DRAIN + 1 CHECK).
- Start accepted at edge E0: done is high in the cycle after edge E0+7k, where k is the number of iterations.
- PU latency is fixed at 2; the result issued in cycle c is captured at the edge ending cycle c+2.
- Result sums fit in 12 bits: worst case 15·8 + 3·15·8.

## Configuration
- MAXNET_ITER_LIMIT_EN
  - Defined: CHECK terminates after MAX_ITER iterations and sets limit_hit.
  - Undefined: no cap and limit_hit is tied to 0. iter_count wraps modulo 2^ITER_W.
  - Undefined with eps=0 and ≥2 non-zero activations never terminates; this is the intended behaviour.

## Structure
- Package maxnet_pkg holds:
  - the state enum;
  - constants W_ONE=5'sd8, FRAC=3, ACT_MAX=15, LANES=4.
- Sub-module maxnet_result_pipe: 2-stage valid/index delay line matching PU latency.
- The PU is not instantiated inside this block; both are connected at the top level.

## Test plan
- din=3,7,5,2, eps=2 → after iterations: 0,4,2,0 then 0,3,1,0 then 0,2,0,0.
  - iter_count=3, winner=1, winner_valid=1, done 21 edges after start.
- din=5,5,0,0, eps=2 → 3,3 → 2,2 → 1,1 → 0,0.
  - iter_count=4, winner_valid=0, winner=0.
- din=0,9,0,0, any eps → one iteration, act unchanged, winner=1, done after 7 edges.
- With the macro defined: din=4,4,4,0, eps=0, MAX_ITER=4 → limit_hit=1, iter_count=4, act=4,4,4,0, winner=0, winner_valid=0.
- rst asserted during DRAIN of iteration 2 → busy=0 immediately, all outputs 0, no done.
  - A following start with din=3,7,5,2 repeats the first scenario's results exactly.
- start held high throughout → a new competition is accepted only in the cycle after DONE.
  - eps=12 behaves identically to eps=8.
